// File: rtl/fifo_arbiter.sv
// rtl/fifo_arbiter.sv - round-robin byte push arbiter feeding a TX FIFO, plus pop sequencer driving a UART TX
//
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   req, req_data                  per-requester push request and byte (requester i on [DW*i +: DW])
//   gnt, fifo_push, fifo_push_data combinational one-hot grant, push strobe and granted byte
//   fifo_full, fifo_empty          FIFO status flags
//   fifo_pop_data                  FIFO head byte
//   fifo_pop                       registered one-cycle pop strobe
//   tx_busy, tx_done               UART TX busy level and completion pulse
//   tx_start, tx_data              registered one-cycle start pulse and byte held for the UART
//   sent_cnt                       wrapping count of bytes handed to the UART
module fifo_arbiter #(
    parameter int N_REQ = 4,
    parameter int DW    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [N_REQ-1:0]      req,
    input  logic [N_REQ*DW-1:0]   req_data,
    output logic [N_REQ-1:0]      gnt,
    output logic                  fifo_push,
    output logic [DW-1:0]         fifo_push_data,
    input  logic                  fifo_full,
    input  logic                  fifo_empty,
    input  logic [DW-1:0]         fifo_pop_data,
    output logic                  fifo_pop,
    input  logic                  tx_busy,
    input  logic                  tx_done,
    output logic                  tx_start,
    output logic [DW-1:0]         tx_data,
    output logic [15:0]           sent_cnt
);

    localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    state_t          r_state;
    logic [PW-1:0]   r_rr_ptr;
    logic            r_fifo_pop;
    logic            r_tx_start;
    logic [DW-1:0]   r_tx_data;
    logic [15:0]     r_sent_cnt;

    logic [N_REQ-1:0] w_gnt;
    logic [PW-1:0]    w_gnt_idx;
    logic             w_gnt_vld;
    logic [PW-1:0]    w_idx;

    // Scan requesters starting at the round-robin pointer. The pointer-plus-offset
    // index wraps naturally in PW bits because N_REQ is a power of two.
    always_comb begin
        w_gnt     = '0;
        w_gnt_idx = '0;
        w_gnt_vld = 1'b0;
        w_idx     = '0;
        for (int i = 0; i < N_REQ; i++) begin
            w_idx = r_rr_ptr + PW'(i);
            if (!w_gnt_vld && req[w_idx]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_idx;
            end
        end
        // No grant while the FIFO cannot accept a byte or while reset is held.
        if (rst || fifo_full) begin
            w_gnt_vld = 1'b0;
        end
        if (w_gnt_vld) begin
            w_gnt[w_gnt_idx] = 1'b1;
        end
    end

    assign gnt            = w_gnt;
    assign fifo_push      = w_gnt_vld;
    assign fifo_push_data = w_gnt_vld ? req_data[w_gnt_idx*DW +: DW] : '0;

    // The requester just served drops to lowest priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (w_gnt_vld) begin
            r_rr_ptr <= w_gnt_idx + PW'(1);
        end
    end

    // Pop sequencer: one byte in flight at a time; the next pop waits for tx_done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_fifo_pop <= 1'b0;
            r_tx_start <= 1'b0;
            r_tx_data  <= '0;
            r_sent_cnt <= '0;
        end else begin
            r_fifo_pop <= 1'b0;
            r_tx_start <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (!fifo_empty && !tx_busy) begin
                        r_state    <= S_START;
                        r_tx_data  <= fifo_pop_data;
                        r_fifo_pop <= 1'b1;
                        r_tx_start <= 1'b1;
                        r_sent_cnt <= r_sent_cnt + 16'd1;
                    end
                end
                S_START: begin
                    // tx_done here belongs to no byte of ours and is ignored.
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (tx_done) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign fifo_pop = r_fifo_pop;
    assign tx_start = r_tx_start;
    assign tx_data  = r_tx_data;
    assign sent_cnt = r_sent_cnt;

endmodule

// File: tb/tb_fifo_arbiter.sv
// tb/tb_fifo_arbiter.sv - self-checking bench for fifo_arbiter
module tb_fifo_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic        fifo_push;
    logic [7:0]  fifo_push_data;
    logic        fifo_full;
    logic        fifo_empty;
    logic [7:0]  fifo_pop_data;
    logic        fifo_pop;
    logic        tx_busy;
    logic        tx_done;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic [15:0] sent_cnt;

    always #5 clk = ~clk;

    fifo_arbiter #(.N_REQ(4), .DW(8)) dut (
        .clk            (clk),
        .rst            (rst),
        .req            (req),
        .req_data       (req_data),
        .gnt            (gnt),
        .fifo_push      (fifo_push),
        .fifo_push_data (fifo_push_data),
        .fifo_full      (fifo_full),
        .fifo_empty     (fifo_empty),
        .fifo_pop_data  (fifo_pop_data),
        .fifo_pop       (fifo_pop),
        .tx_busy        (tx_busy),
        .tx_done        (tx_done),
        .tx_start       (tx_start),
        .tx_data        (tx_data),
        .sent_cnt       (sent_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference model state for the random phase
    int          m_ptr;
    logic [15:0] exp_sent;
    bit          window;
    bit          exp_start;
    bit          next_start;
    bit          start_prev;
    logic [7:0]  q[$];
    logic [7:0]  sb[$];
    bit          pend[4];
    logic [7:0]  dat[4];
    bit          uart_active;
    int          rem;
    int          exp_k;
    int          idx;
    logic [3:0]  exp_gnt;
    logic [7:0]  exp_pdata;
    logic [31:0] pattern;
    int          n_pend;

    initial begin
        rst = 1'b1; req = '0; req_data = '0; fifo_full = 1'b0; fifo_empty = 1'b1;
        fifo_pop_data = '0; tx_busy = 1'b0; tx_done = 1'b0;
        step(); step();

        // Reset state, grant suppressed while reset is high
        req = 4'hF; pattern = 32'h44332211; req_data = pattern; #1;
        check("rst_gnt", 32'(gnt), 32'h0);
        check("rst_push", 32'(fifo_push), 32'h0);
        check("rst_pdata", 32'(fifo_push_data), 32'h0);
        check("rst_tx_start", 32'(tx_start), 32'h0);
        check("rst_fifo_pop", 32'(fifo_pop), 32'h0);
        check("rst_tx_data", 32'(tx_data), 32'h0);
        check("rst_sent_cnt", 32'(sent_cnt), 32'h0);

        // All requesting: strict rotation 0,1,2,3,0,...
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            #1;
            check("rr_all_gnt", 32'(gnt), 32'(1 << (i % 4)));
            check("rr_all_push", 32'(fifo_push), 32'h1);
            check("rr_all_pdata", 32'(fifo_push_data), (pattern >> (8 * (i % 4))) & 32'hFF);
            step();
        end

        // Bring pointer to 1, then req=0101 sequence
        req = 4'b0001; #1;
        check("ptr_to1_gnt", 32'(gnt), 32'h1);
        step();
        req = 4'b0101; #1;
        check("r0101_a", 32'(gnt), 32'h4);
        step();
        #1;
        check("r0101_b", 32'(gnt), 32'h1);
        step();
        req = 4'hF; #1;
        check("ptr_back1", 32'(gnt), 32'h2);
        step();

        // FIFO full blocks grants and freezes the pointer (pointer is 2)
        fifo_full = 1'b1;
        for (int i = 0; i < 2; i++) begin
            #1;
            check("full_gnt", 32'(gnt), 32'h0);
            check("full_push", 32'(fifo_push), 32'h0);
            check("full_pdata", 32'(fifo_push_data), 32'h0);
            step();
        end
        fifo_full = 1'b0; #1;
        check("after_full_gnt", 32'(gnt), 32'h4);
        step();
        req = 4'h0; #1;
        check("noreq_push", 32'(fifo_push), 32'h0);

        // Single transfer A5 and hold-off until tx_done
        fifo_empty = 1'b0; fifo_pop_data = 8'hA5; tx_busy = 1'b0; #1;
        check("idle_no_start", 32'(tx_start), 32'h0);
        step();
        check("a5_tx_start", 32'(tx_start), 32'h1);
        check("a5_fifo_pop", 32'(fifo_pop), 32'h1);
        check("a5_tx_data", 32'(tx_data), 32'hA5);
        check("a5_sent_cnt", 32'(sent_cnt), 32'h1);
        fifo_pop_data = 8'h5A;
        for (int i = 0; i < 4; i++) begin
            step();
            check("wait_no_start", 32'(tx_start), 32'h0);
            check("wait_no_pop", 32'(fifo_pop), 32'h0);
            check("wait_tx_data", 32'(tx_data), 32'hA5);
        end
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        check("idle_gap", 32'(tx_start), 32'h0);
        step();
        check("second_start", 32'(tx_start), 32'h1);
        check("second_data", 32'(tx_data), 32'h5A);
        check("second_cnt", 32'(sent_cnt), 32'h2);
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("done_in_start_ignored", 32'(tx_start), 32'h0);
        end

        // Reset during WAIT
        rst = 1'b1;
        step();
        check("rst_wait_start", 32'(tx_start), 32'h0);
        check("rst_wait_pop", 32'(fifo_pop), 32'h0);
        check("rst_wait_cnt", 32'(sent_cnt), 32'h0);
        check("rst_wait_data", 32'(tx_data), 32'h0);
        req = 4'hF; #1;
        check("rst_hold_gnt", 32'(gnt), 32'h0);
        check("rst_hold_push", 32'(fifo_push), 32'h0);
        step();
        check("rst_hold_start", 32'(tx_start), 32'h0);
        rst = 1'b0; req = 4'h0; fifo_empty = 1'b1;
        step();
        check("post_rst_start_a", 32'(tx_start), 32'h0);
        step();
        check("post_rst_start_b", 32'(tx_start), 32'h0);
        fifo_empty = 1'b0; fifo_pop_data = 8'h3C;
        step();
        check("post_rst_idle_start", 32'(tx_start), 32'h1);
        check("post_rst_cnt", 32'(sent_cnt), 32'h1);
        fifo_empty = 1'b1;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;

        // sent_cnt wrap
        force dut.r_sent_cnt = 16'hFFFF;
        #1;
        release dut.r_sent_cnt;
        check("preload_cnt", 32'(sent_cnt), 32'hFFFF);
        fifo_empty = 1'b0; fifo_pop_data = 8'h77;
        step();
        check("wrap_start", 32'(tx_start), 32'h1);
        check("wrap_cnt", 32'(sent_cnt), 32'h0);
        fifo_empty = 1'b1;
        step();
        tx_done = 1'b1;
        step();
        tx_done = 1'b0;

        // Random phase: bench owns a 4-deep FIFO and a UART model
        rst = 1'b1; req = '0; fifo_full = 1'b0; fifo_empty = 1'b1; tx_busy = 1'b0; tx_done = 1'b0;
        step(); step();
        rst = 1'b0;
        m_ptr = 0; exp_sent = '0; window = 1'b0; exp_start = 1'b0; start_prev = 1'b0;
        uart_active = 1'b0; rem = 0;
        for (int i = 0; i < 4; i++) begin
            pend[i] = 1'b0;
            dat[i]  = '0;
        end
        for (int cyc = 0; cyc < 700; cyc++) begin
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && cyc < 600 && $urandom_range(0, 2) == 0) begin
                    pend[i] = 1'b1;
                    dat[i]  = 8'($urandom);
                end
                req[i] = pend[i];
                req_data[8*i +: 8] = dat[i];
            end
            fifo_full     = (q.size() >= 4);
            fifo_empty    = (q.size() == 0);
            fifo_pop_data = (q.size() == 0) ? 8'h00 : q[0];
            #1;

            exp_k = -1;
            if (!fifo_full) begin
                for (int j = 0; j < 4; j++) begin
                    idx = (m_ptr + j) % 4;
                    if (exp_k < 0 && pend[idx]) exp_k = idx;
                end
            end
            exp_gnt   = (exp_k >= 0) ? 4'(1 << exp_k) : 4'h0;
            exp_pdata = (exp_k >= 0) ? dat[exp_k] : 8'h00;
            check("rnd_gnt", 32'(gnt), 32'(exp_gnt));
            check("rnd_push", 32'(fifo_push), 32'(exp_k >= 0));
            check("rnd_pdata", 32'(fifo_push_data), 32'(exp_pdata));
            check("rnd_tx_start", 32'(tx_start), 32'(exp_start));
            check("rnd_fifo_pop", 32'(fifo_pop), 32'(exp_start));
            check("rnd_sent_cnt", 32'(sent_cnt), 32'(exp_sent));

            if (exp_start) begin
                window = 1'b1;
                if (sb.size() == 0) begin
                    check("rnd_sb_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    check("rnd_tx_data", 32'(tx_data), 32'(sb[0]));
                    void'(sb.pop_front());
                end
                if (q.size() > 0) void'(q.pop_front());
            end
            next_start = !window && !fifo_empty && !tx_busy;
            if (tx_done && window && !exp_start) window = 1'b0;
            if (exp_k >= 0) begin
                q.push_back(dat[exp_k]);
                sb.push_back(dat[exp_k]);
                pend[exp_k] = 1'b0;
                m_ptr = (exp_k + 1) % 4;
            end
            start_prev = exp_start;
            exp_start  = next_start;
            if (next_start) exp_sent = exp_sent + 16'd1;

            step();

            tx_done = 1'b0;
            if (start_prev) begin
                uart_active = 1'b1;
                rem = $urandom_range(0, 3);
            end
            if (uart_active) begin
                if (rem == 0) begin
                    tx_done = 1'b1;
                    tx_busy = 1'b0;
                    uart_active = 1'b0;
                end else begin
                    tx_busy = 1'b1;
                    rem--;
                end
            end else begin
                tx_busy = ($urandom_range(0, 5) == 0);
            end
        end

        n_pend = 0;
        for (int i = 0; i < 4; i++) n_pend += int'(pend[i]);
        check("drain_sb_empty", 32'(sb.size()), 32'd0);
        check("drain_no_pending", 32'(n_pend), 32'd0);
        check("final_sent_cnt", 32'(sent_cnt), 32'(exp_sent));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_arbiter.md
FIFO_ARBITER -- requirements
Module: fifo_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of byte requesters sharing one TX FIFO (fixed 4 in this release).
REQ-002 Parameter DW, default 8, byte width.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 req  input  4  per-requester push request; requester holds req and its data until its gnt bit is seen.
REQ-006 req_data  input  32  requester i byte on bits [8i+7:8i].
REQ-007 gnt  output  4  one-hot combinational grant; bit i high = req_data byte i pushed this cycle.
REQ-008 fifo_push  output  1  combinational push strobe to FIFO.
REQ-009 fifo_push_data  output  8  combinational byte of granted requester; 0 when no grant.
REQ-010 fifo_full, fifo_empty  input  1 each  FIFO status flags.
REQ-011 fifo_pop_data  input  8  FIFO head byte, combinational, valid while fifo_empty=0.
REQ-012 fifo_pop  output  1  registered, one-cycle pop strobe.
REQ-013 tx_busy, tx_done  input  1 each  UART TX busy level and one-cycle completion pulse.
REQ-014 tx_start  output  1  registered, one-cycle start pulse to UART TX.
REQ-015 tx_data  output  8  registered byte presented to UART TX, stable from tx_start until next load.
REQ-016 sent_cnt  output  16  count of bytes handed to TX.

Function
REQ-017 Push arbitration: round-robin over req using 2-bit pointer rr_ptr; requester rr_ptr has highest priority, then rr_ptr+1, ... mod 4.
REQ-018 When fifo_full=1, gnt=0 and fifo_push=0 regardless of req.
REQ-019 When fifo_full=0 and req!=0, exactly one gnt bit high, fifo_push=1, same cycle.
REQ-020 On a grant to index k, rr_ptr <= k+1 (mod 4, 3 wraps to 0); otherwise rr_ptr holds.
REQ-021 At most one push per cycle; non-granted requesters wait, no bytes dropped by the arbiter.
REQ-022 Pop sequencer FSM states IDLE, START, WAIT.
REQ-023 IDLE -> START when fifo_empty=0 and tx_busy=0; on that edge tx_data <= fifo_pop_data.
REQ-024 In START: fifo_pop=1, tx_start=1 (exactly one cycle each); sent_cnt increments by 1, wrapping FFFF->0000; START -> WAIT unconditionally.
REQ-025 In WAIT: fifo_pop=0, tx_start=0; WAIT -> IDLE on tx_done=1, else hold.
REQ-026 Minimum byte-to-byte spacing: START, WAIT (>=1 cycle), IDLE, START = 3 cycles; no second pop before tx_done.
REQ-027 Simultaneous push and pop in one cycle permitted; arbiter and sequencer independent.
REQ-028 tx_done in IDLE or START ignored.
REQ-029 First byte latency: push at cycle t into empty FIFO -> tx_start at t+2 (fifo_empty falls t+1, START t+2).

Reset
REQ-030 rst=1 at a clock edge: state <= IDLE, rr_ptr <= 0, tx_data <= 0, sent_cnt <= 0, fifo_pop/tx_start <= 0.
REQ-031 Reset mid-operation (START or WAIT) aborts the transfer with no further pop or start; gnt/fifo_push remain combinational from inputs during reset but shall be held 0 while rst=1.

Verification
REQ-032 All req=4'b1111, fifo_full=0 for 8 cycles -> gnt sequence 0001,0010,0100,1000,0001,... and fifo_push=1 each cycle.
REQ-033 req=4'b0101, rr_ptr=1 -> gnt=0100; next cycle gnt=0001; rr_ptr then 3 then 1.
REQ-034 fifo_full=1 with req=4'b1111 -> gnt=0, fifo_push=0, rr_ptr unchanged.
REQ-035 fifo_empty=0, fifo_pop_data=8'hA5, tx_busy=0 -> next cycle tx_start=1, fifo_pop=1, tx_data=8'hA5, sent_cnt=1; no further start until tx_done pulse.
REQ-036 rst asserted during WAIT -> next cycle state IDLE, sent_cnt=0, tx_data=0; no tx_start for the interrupted byte.
REQ-037 sent_cnt preloaded to 16'hFFFF via 65535 transfers (or forced) -> next transfer sets sent_cnt=16'h0000.
